// File: rtl/uart_btint_pkg.sv
// Shared types and helpers for the BTint UART column streamer.
// Optional overflow frames are enabled in the top with UART_BTINT_OVERFLOW_TX_EN.
package uart_btint_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START_BIT,
    DATA_BIT,
    STOP_BIT
  } tx_state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned OVERFLOW_WIDTH  = 2;

  // Interleave a 4-digit group into frame order a0,b0,a1,b1,a2,b2,a3,b3 (bit 0 first).
  function automatic logic [FRAME_DATA_BITS-1:0] build_frame(input logic [3:0] digits_a,
                                                             input logic [3:0] digits_b);
    logic [FRAME_DATA_BITS-1:0] frame;
    for (int i = 0; i < 4; i++) begin
      frame[2*i]   = digits_a[i];
      frame[2*i+1] = digits_b[i];
    end
    return frame;
  endfunction

endpackage

// File: rtl/uart_btint_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT cycles per UART bit and strobes bit_end on the
// last cycle of each period. Reloads itself so consecutive bits need no extra load.
module uart_btint_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 10000000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_load,
  input  logic i_run,
  output logic o_bit_end
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  // Down-counter: load at job start, reload on every period end while running.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (i_run) begin
      if (r_cnt == '0) begin
        r_cnt <= RELOAD;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_bit_end = i_run && (r_cnt == '0);

endmodule

// File: rtl/uart_btint_streamer.sv
// Streams a ROWS x COLS matrix of BTint elements (digit pairs a/b plus 2-bit overflow)
// over a UART TX line, one selected column or the whole matrix per job.
// Define UART_BTINT_OVERFLOW_TX_EN to append one overflow frame after each element.
module uart_btint_streamer
  import uart_btint_pkg::*;
#(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned CLKS_PER_BIT = 10000000,
  parameter int unsigned STOP_BITS    = 2
) (
  input  logic                               uart_btint_streamer_clock,
  input  logic                               uart_btint_streamer_reset_active_high,
  input  logic [ROWS*COLS*DIGITS-1:0]        uart_btint_streamer_input_btint_a,
  input  logic [ROWS*COLS*DIGITS-1:0]        uart_btint_streamer_input_btint_b,
  input  logic [ROWS*COLS*OVERFLOW_WIDTH-1:0] uart_btint_streamer_input_overflow,
  input  logic signed [31:0]                 uart_btint_streamer_column,
  input  logic                               uart_btint_streamer_all_columns,
  input  logic                               uart_btint_streamer_start,
  output logic                               uart_btint_streamer_ready,
  output logic                               uart_btint_streamer_output,
  output logic                               uart_btint_streamer_done,
  output logic                               uart_btint_streamer_error
);

  localparam int unsigned DATA_W       = ROWS * COLS * DIGITS;
  localparam int unsigned OVF_W        = ROWS * COLS * OVERFLOW_WIDTH;
  localparam int unsigned DIGIT_FRAMES = DIGITS / 4;
`ifdef UART_BTINT_OVERFLOW_TX_EN
  localparam int unsigned OVF_FRAMES   = 1;
`else
  localparam int unsigned OVF_FRAMES   = 0;
`endif
  localparam int unsigned ELEM_FRAMES  = DIGIT_FRAMES + OVF_FRAMES;
  localparam int unsigned FRAME_W      = (ELEM_FRAMES > 1) ? $clog2(ELEM_FRAMES) : 1;
  localparam int unsigned ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W        = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned BIT_W        = $clog2(FRAME_DATA_BITS);
  localparam int unsigned STOP_W       = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

  tx_state_e            r_state;
  logic                 r_tx;
  logic                 r_ready;
  logic                 r_done;
  logic                 r_error;
  logic                 r_all;
  logic [FRAME_W-1:0]   r_frame;
  logic [ROW_W-1:0]     r_row;
  logic [COL_W-1:0]     r_col;
  logic [BIT_W-1:0]     r_bit;
  logic [STOP_W-1:0]    r_stop;
  logic [DATA_W-1:0]    r_a;
  logic [DATA_W-1:0]    r_b;
  logic [OVF_W-1:0]     r_ovf;

  logic                       w_accept;
  logic                       w_col_bad;
  logic                       w_load;
  logic                       w_bit_end;
  logic                       w_last_frame;
  logic                       w_last_row;
  logic                       w_last_col;
  logic                       w_job_last;
  int unsigned                w_elem;
  int unsigned                w_dframe;
  logic [3:0]                 w_nib_a;
  logic [3:0]                 w_nib_b;
  logic [FRAME_DATA_BITS-1:0] w_frame_data;

  assign w_accept  = uart_btint_streamer_start && r_ready;
  // Negative columns show up as the sign bit; the rest compares as unsigned.
  assign w_col_bad = !uart_btint_streamer_all_columns &&
                     (uart_btint_streamer_column[31] ||
                      (uart_btint_streamer_column[30:0] >= 31'(COLS)));
  assign w_load    = w_accept && !w_col_bad;

  assign w_last_frame = (r_frame == FRAME_W'(ELEM_FRAMES - 1));
  assign w_last_row   = (r_row == ROW_W'(ROWS - 1));
  assign w_last_col   = !r_all || (r_col == COL_W'(COLS - 1));
  assign w_job_last   = w_last_frame && w_last_row && w_last_col;

  assign w_elem   = 32'(r_row) * COLS + 32'(r_col);
  // The overflow frame index has no digit group; clamp to keep the slice in range.
  assign w_dframe = (32'(r_frame) < DIGIT_FRAMES) ? 32'(r_frame) : 32'd0;
  assign w_nib_a  = r_a[w_elem*DIGITS + w_dframe*4 +: 4];
  assign w_nib_b  = r_b[w_elem*DIGITS + w_dframe*4 +: 4];

`ifdef UART_BTINT_OVERFLOW_TX_EN
  logic [OVERFLOW_WIDTH-1:0] w_ovf_bits;
  assign w_ovf_bits = r_ovf[w_elem*OVERFLOW_WIDTH +: OVERFLOW_WIDTH];

  // Current frame payload: digit group, or the element's overflow flag after its digits.
  always_comb begin
    w_frame_data = build_frame(w_nib_a, w_nib_b);
    if (r_frame == FRAME_W'(DIGIT_FRAMES)) begin
      w_frame_data = {{(FRAME_DATA_BITS - OVERFLOW_WIDTH){1'b0}}, w_ovf_bits};
    end
  end
`else
  logic w_unused_ovf;
  assign w_unused_ovf = ^r_ovf;

  // Current frame payload: always a digit group.
  always_comb begin
    w_frame_data = build_frame(w_nib_a, w_nib_b);
  end
`endif

  uart_btint_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk    (uart_btint_streamer_clock),
    .i_reset  (uart_btint_streamer_reset_active_high),
    .i_load   (w_load),
    .i_run    (r_state != IDLE),
    .o_bit_end(w_bit_end)
  );

  // Snapshot the matrix on acceptance so later input changes cannot disturb the job.
  always_ff @(posedge uart_btint_streamer_clock) begin
    if (w_load) begin
      r_a   <= uart_btint_streamer_input_btint_a;
      r_b   <= uart_btint_streamer_input_btint_b;
      r_ovf <= uart_btint_streamer_input_overflow;
    end
  end

  // Transmit FSM with registered line, ready, done and error.
  always_ff @(posedge uart_btint_streamer_clock) begin
    if (uart_btint_streamer_reset_active_high) begin
      r_state <= IDLE;
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      r_all   <= 1'b0;
      r_frame <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_bit   <= '0;
      r_stop  <= '0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_col_bad) begin
              r_error <= 1'b1;
            end else begin
              r_state <= START_BIT;
              r_tx    <= 1'b0;
              r_ready <= 1'b0;
              r_all   <= uart_btint_streamer_all_columns;
              r_col   <= uart_btint_streamer_all_columns ? '0
                                                         : uart_btint_streamer_column[COL_W-1:0];
              r_frame <= '0;
              r_row   <= '0;
              r_bit   <= '0;
              r_stop  <= '0;
            end
          end
        end
        START_BIT: begin
          if (w_bit_end) begin
            r_state <= DATA_BIT;
            r_tx    <= w_frame_data[0];
            r_bit   <= '0;
          end
        end
        DATA_BIT: begin
          if (w_bit_end) begin
            if (r_bit == BIT_W'(FRAME_DATA_BITS - 1)) begin
              r_state <= STOP_BIT;
              r_tx    <= 1'b1;
              r_stop  <= '0;
            end else begin
              r_bit <= r_bit + BIT_W'(1);
              r_tx  <= w_frame_data[r_bit + BIT_W'(1)];
            end
          end
        end
        STOP_BIT: begin
          if (w_bit_end) begin
            if (r_stop != STOP_W'(STOP_BITS - 1)) begin
              r_stop <= r_stop + STOP_W'(1);
            end else if (w_job_last) begin
              r_state <= IDLE;
              r_ready <= 1'b1;
              r_done  <= 1'b1;
              r_frame <= '0;
              r_row   <= '0;
              r_col   <= '0;
            end else begin
              // Next frame follows immediately: frame, then row, then column.
              r_state <= START_BIT;
              r_tx    <= 1'b0;
              r_bit   <= '0;
              r_frame <= w_last_frame ? '0 : r_frame + FRAME_W'(1);
              if (w_last_frame) begin
                r_row <= w_last_row ? '0 : r_row + ROW_W'(1);
                if (w_last_row) begin
                  r_col <= r_col + COL_W'(1);
                end
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign uart_btint_streamer_ready  = r_ready;
  assign uart_btint_streamer_output = r_tx;
  assign uart_btint_streamer_done   = r_done;
  assign uart_btint_streamer_error  = r_error;

endmodule

// File: tb/tb_uart_btint_streamer.sv
// Randomised bench for uart_btint_streamer with a per-cycle line model built from
// frame contents, plus directed literal checks of frame bits and job durations.
module tb_uart_btint_streamer;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int DIGITS    = 8;
  localparam int CPB       = 4;
  localparam int STOP      = 2;
  localparam int W         = ROWS * COLS * DIGITS;
  localparam int OW        = ROWS * COLS * 2;
  localparam int FRAME_CYC = (9 + STOP) * CPB;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [W-1:0]         in_a = '0;
  logic [W-1:0]         in_b = '0;
  logic [OW-1:0]        in_ovf = '0;
  logic signed [31:0]   col = 0;
  logic                 all = 1'b0;
  logic                 start = 1'b0;
  logic                 rdy, tx, done, err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model state
  bit  line_q[$];
  bit  exp_tx = 1'b1, exp_ready = 1'b1, exp_done = 1'b0, exp_error = 1'b0;
  bit  job_active = 1'b0;

  always #5 clk = ~clk;

  uart_btint_streamer #(
    .ROWS(ROWS), .COLS(COLS), .DIGITS(DIGITS), .CLKS_PER_BIT(CPB), .STOP_BITS(STOP)
  ) dut (
    .uart_btint_streamer_clock            (clk),
    .uart_btint_streamer_reset_active_high(rst),
    .uart_btint_streamer_input_btint_a    (in_a),
    .uart_btint_streamer_input_btint_b    (in_b),
    .uart_btint_streamer_input_overflow   (in_ovf),
    .uart_btint_streamer_column           (col),
    .uart_btint_streamer_all_columns      (all),
    .uart_btint_streamer_start            (start),
    .uart_btint_streamer_ready            (rdy),
    .uart_btint_streamer_output           (tx),
    .uart_btint_streamer_done             (done),
    .uart_btint_streamer_error            (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame byte k-th bit = digit (4f + k/2) of a (k even) or b (k odd).
  function automatic logic [7:0] frame_byte(input int r, input int c, input int f);
    logic [7:0] v;
    for (int k = 0; k < 8; k++) begin
      int idx = (r * COLS + c) * DIGITS + 4 * f + k / 2;
      v[k] = (k % 2 == 0) ? in_a[idx] : in_b[idx];
    end
    return v;
  endfunction

  task automatic push_frame(input logic [7:0] v);
    repeat (CPB) line_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) repeat (CPB) line_q.push_back(v[k]);
    repeat (CPB * STOP) line_q.push_back(1'b1);
  endtask

  task automatic push_job(input int c0, input int nc);
    for (int c = c0; c < c0 + nc; c++)
      for (int r = 0; r < ROWS; r++) begin
        for (int f = 0; f < DIGITS / 4; f++) push_frame(frame_byte(r, c, f));
`ifdef UART_BTINT_OVERFLOW_TX_EN
        push_frame({6'b0, in_ovf[(r * COLS + c) * 2 +: 2]});
`endif
      end
  endtask

  // Reference model: expected line/ready/done/error for the cycle after each edge.
  always @(posedge clk) begin
    if (rst) begin
      line_q.delete();
      exp_tx = 1'b1; exp_ready = 1'b1; exp_done = 1'b0; exp_error = 1'b0;
      job_active = 1'b0;
    end else begin
      exp_done  = 1'b0;
      exp_error = 1'b0;
      if (start && exp_ready) begin
        if (!all && (col < 0 || col >= COLS)) exp_error = 1'b1;
        else push_job(all ? 0 : int'(col), all ? COLS : 1);
      end
      if (line_q.size() > 0) begin
        exp_tx = line_q.pop_front();
        exp_ready = 1'b0;
        job_active = 1'b1;
      end else begin
        exp_tx = 1'b1;
        exp_ready = 1'b1;
        exp_done = job_active;
        job_active = 1'b0;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("line", tx, exp_tx);
      check("ready", rdy, exp_ready);
      check("done", done, exp_done);
      check("error", err, exp_error);
    end
  end

  task automatic rand_inputs();
    logic [31:0] r = '0;
    for (int i = 0; i < W; i++) begin
      if (i % 32 == 0) r = $urandom;
      in_a[i] = r[i % 32];
    end
    for (int i = 0; i < W; i++) begin
      if (i % 32 == 0) r = $urandom;
      in_b[i] = r[i % 32];
    end
    for (int i = 0; i < OW; i++) begin
      if (i % 32 == 0) r = $urandom;
      in_ovf[i] = r[i % 32];
    end
  endtask

  task automatic wait_ready(input int budget);
    int n = 0;
    while (!rdy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", rdy, 1);
  endtask

  // Run an accepted job until done; return cycles from accept edge to done (-1 on timeout).
  task automatic run_to_done(output int done_k, output int n_done);
    done_k = -1;
    n_done = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done) begin
        n_done++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k > done_k + 4) break;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, done_k, n_done;
    logic [7:0] fr [0:2];
    for (int f = 0; f < 3; f++) fr[f] = '0;

    // Reset held 3 cycles
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_ready", rdy, 1);
    check("reset_line", tx, 1);
    check("reset_done", done, 0);
    check("reset_error", err, 0);
    rst = 1'b0;

    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx === 1'b1) hi++;
    end
    check("idle_line_high", hi, 100);

    // Single column 2, element (0,2) a=A5 b=0F, overflow 2'b10
    rand_inputs();
    in_a[2 * DIGITS +: DIGITS] = 8'hA5;
    in_b[2 * DIGITS +: DIGITS] = 8'h0F;
    in_ovf[2 * 2 +: 2] = 2'b10;
    col = 2; all = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("accept_line_low", tx, 0);
    check("accept_ready_low", rdy, 0);
    rand_inputs();
    done_k = -1;
    for (int k = 0; k < 3000; k++) begin
      for (int f = 0; f < 3; f++)
        for (int j = 0; j < 8; j++)
          if (k == FRAME_CYC * f + CPB * (1 + j) + 1) fr[f][j] = tx;
      if (done) begin
        done_k = k;
        break;
      end
      @(negedge clk);
    end
    check("col2_frame0", fr[0], 8'hBB);
    check("col2_frame1", fr[1], 8'h44);
`ifdef UART_BTINT_OVERFLOW_TX_EN
    check("col2_ovf_frame", fr[2], 8'h02);
    check("col2_duration", done_k, 528);
`else
    check("col2_duration", done_k, 352);
`endif

    // All-columns job
    @(negedge clk);
    wait_ready(50);
    rand_inputs();
    col = 9; all = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_done(done_k, n_done);
`ifdef UART_BTINT_OVERFLOW_TX_EN
    check("all_duration", done_k, 2112);
`else
    check("all_duration", done_k, 1408);
`endif
    check("all_done_pulses", n_done, 1);

    // Out-of-range columns: 7 and -1
    for (int t = 0; t < 2; t++) begin
      wait_ready(50);
      col = (t == 0) ? 7 : -1; all = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("badcol_error", err, 1);
      check("badcol_ready", rdy, 1);
      check("badcol_line", tx, 1);
      @(negedge clk);
      check("badcol_error_clear", err, 0);
      check("badcol_line_idle", tx, 1);
    end

    // Reset during data bits of frame 2, then a fresh job
    rand_inputs();
    col = 1; all = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (FRAME_CYC * 2 + CPB * 3 + 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_line", tx, 1);
    check("midrst_ready", rdy, 1);
    rst = 1'b0;
    @(negedge clk);
    rand_inputs();
    col = 3; all = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    run_to_done(done_k, n_done);
    check("after_rst_done_pulses", n_done, 1);

    // Random traffic, including starts while busy and back-to-back starts
    for (int cyc = 0; cyc < 2500; cyc++) begin
      rand_inputs();
      col   = $signed($urandom_range(0, 6)) - 1;
      all   = ($urandom_range(0, 24) == 0);
      start = ($urandom_range(0, 3) == 0) || (cyc % 400 < 60);
      @(negedge clk);
    end
    start = 1'b0;
    wait_ready(3000);
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
